// File: rtl/matrix_frame_sequencer.sv
// Walks the frame buffer once per frame and feeds output_module one word per step,
// pacing every new_image / next_data / new_column command on the tx_finish handshake.
module matrix_frame_sequencer #(
  parameter int CHANNEL_NUMBER   = 3,
  parameter int SPI_SIZE         = 8,
  parameter int COLUMNS          = 16,
  parameter int BYTES_PER_COLUMN = 24,
  parameter int ADDR_WIDTH       = $clog2(COLUMNS*BYTES_PER_COLUMN)
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               enable,
  output logic                               rd_en,
  output logic [ADDR_WIDTH-1:0]              rd_addr,
  input  logic [CHANNEL_NUMBER*SPI_SIZE-1:0] rd_data,
  output logic [CHANNEL_NUMBER*SPI_SIZE-1:0] data_out,
  output logic                               new_image,
  output logic                               new_column,
  output logic                               next_data,
  input  logic                               tx_finish,
  output logic                               frame_done,
  output logic                               busy
);

  // state     | meaning
  // IDLE      | waiting for enable with output_module idle
  // IMG       | new_image pulse, counters and address cleared
  // FETCH     | frame-buffer read at rd_addr
  // LOAD      | rd_data presented on data_out, next_data pulse
  // STEP      | advance byte counter and address
  // COL       | new_column pulse
  // CSTEP     | advance column or close the frame
  // WAIT_BUSY | command issued, waiting for tx_finish low
  // WAIT_DONE | output_module busy, waiting for tx_finish high

  localparam int TOTAL = COLUMNS * BYTES_PER_COLUMN;
  localparam int BW    = (BYTES_PER_COLUMN > 1) ? $clog2(BYTES_PER_COLUMN) : 1;
  localparam int CW    = (COLUMNS > 1) ? $clog2(COLUMNS) : 1;
  localparam logic [BW-1:0]         BYTE_LAST = BW'(BYTES_PER_COLUMN - 1);
  localparam logic [CW-1:0]         COL_LAST  = CW'(COLUMNS - 1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = ADDR_WIDTH'(TOTAL - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_IMG, S_FETCH, S_LOAD, S_STEP, S_COL, S_CSTEP, S_WAIT_BUSY, S_WAIT_DONE
  } state_t;

  state_t state_q, state_d;
  state_t ret_q, ret_d;
  logic [BW-1:0] byte_q;
  logic [CW-1:0] col_q;
  logic [CHANNEL_NUMBER*SPI_SIZE-1:0] data_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      ret_q   <= S_IDLE;
      byte_q  <= '0;
      col_q   <= '0;
      rd_addr <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      ret_q   <= ret_d;
      case (state_q)
        S_IMG: begin
          byte_q  <= '0;
          col_q   <= '0;
          rd_addr <= '0;
        end
        S_LOAD: data_q <= rd_data;
        S_STEP: begin
          byte_q  <= (byte_q == BYTE_LAST) ? '0 : byte_q + 1'b1;
          rd_addr <= (rd_addr == ADDR_LAST) ? '0 : rd_addr + 1'b1;
        end
        S_CSTEP: begin
          if (col_q == COL_LAST) begin
            col_q   <= '0;
            rd_addr <= '0;
          end else begin
            col_q <= col_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d    = state_q;
    ret_d      = ret_q;
    rd_en      = 1'b0;
    new_image  = 1'b0;
    next_data  = 1'b0;
    new_column = 1'b0;
    frame_done = 1'b0;
    case (state_q)
      S_IDLE:  if (enable && tx_finish) state_d = S_IMG;
      S_IMG: begin
        new_image = 1'b1;
        ret_d     = S_FETCH;
        state_d   = S_WAIT_BUSY;
      end
      S_FETCH: begin
        rd_en   = 1'b1;
        state_d = S_LOAD;
      end
      S_LOAD: begin
        next_data = 1'b1;
        ret_d     = S_STEP;
        state_d   = S_WAIT_BUSY;
      end
      S_STEP:  state_d = (byte_q == BYTE_LAST) ? S_COL : S_FETCH;
      S_COL: begin
        new_column = 1'b1;
        ret_d      = S_CSTEP;
        state_d    = S_WAIT_BUSY;
      end
      S_CSTEP: begin
        if (col_q == COL_LAST) begin
          frame_done = 1'b1;
          state_d    = enable ? S_IMG : S_IDLE;
        end else begin
          state_d = S_FETCH;
        end
      end
      // a pulse may be followed by tx_finish still high; never re-issue here
      S_WAIT_BUSY: if (!tx_finish) state_d = S_WAIT_DONE;
      S_WAIT_DONE: if (tx_finish) state_d = ret_q;
      default: state_d = S_IDLE;
    endcase
  end

  // the fetched word is visible in the same cycle as its next_data pulse, then held
  assign data_out = (state_q == S_LOAD) ? rd_data : data_q;
  assign busy     = (state_q != S_IDLE);

endmodule

// File: tb/tb_matrix_frame_sequencer.sv
// Randomized bench for matrix_frame_sequencer: output_module and frame-buffer models
// plus an event-list reference built from the frame walk order.
module tb_matrix_frame_sequencer;

  localparam int COLS = 2;
  localparam int BPC  = 3;
  localparam int AW   = 3;
  localparam int DW   = 24;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          enable = 1'b0;
  logic          tx_finish;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data = '0;
  logic [DW-1:0] data_out;
  logic          new_image, new_column, next_data, frame_done, busy;

  matrix_frame_sequencer #(
    .CHANNEL_NUMBER(3), .SPI_SIZE(8), .COLUMNS(COLS), .BYTES_PER_COLUMN(BPC)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data), .data_out(data_out), .new_image(new_image),
    .new_column(new_column), .next_data(next_data), .tx_finish(tx_finish),
    .frame_done(frame_done), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          kind;
    logic [DW-1:0] data;
    int          cyc;
  } ev_t;

  localparam int K_IMG = 0, K_DATA = 1, K_COL = 2, K_DONE = 3;

  ev_t  evq[$];
  ev_t  exp_q[$];
  int   fetchq[$];
  int   exp_a[$];
  logic [DW-1:0] mem [0:COLS*BPC-1];
  int   cyc = 0, viol = 0, hold_viol = 0, hold_hi = 0, busy_len = 4;
  int   tests = 0, fails = 0;
  int   pend_addr = 0;
  bit   pend = 1'b0;

  // output_module model and event monitor, evaluated mid-cycle
  initial begin
    int hi_cnt, bcnt, npulse;
    logic [DW-1:0] prev_data;
    hi_cnt = 0; bcnt = 0; prev_data = '0;
    tx_finish = 1'b1;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        tx_finish = 1'b1; hi_cnt = 0; bcnt = 0; pend = 1'b0;
        prev_data = data_out;
      end else begin
        npulse = int'(new_image) + int'(next_data) + int'(new_column);
        if (npulse > 1) viol++;
        if (npulse > 0 && (!tx_finish || hi_cnt > 0 || bcnt > 0)) viol++;
        if (new_image)  evq.push_back('{K_IMG, data_out, cyc});
        if (next_data)  evq.push_back('{K_DATA, data_out, cyc});
        if (new_column) evq.push_back('{K_COL, data_out, cyc});
        if (frame_done) evq.push_back('{K_DONE, data_out, cyc});
        if (rd_en) begin
          fetchq.push_back(int'(rd_addr));
          pend_addr = int'(rd_addr);
          pend = 1'b1;
        end
        if (data_out !== prev_data && !next_data) hold_viol++;
        prev_data = data_out;
        if (bcnt > 0) begin
          bcnt--;
          if (bcnt == 0) tx_finish = 1'b1;
        end else if (hi_cnt > 0) begin
          hi_cnt--;
          if (hi_cnt == 0) begin tx_finish = 1'b0; bcnt = busy_len; end
        end else if (npulse > 0) begin
          if (hold_hi > 0) hi_cnt = hold_hi;
          else begin tx_finish = 1'b0; bcnt = busy_len; end
        end
      end
    end
  end

  // frame buffer: data appears one cycle after the read strobe
  initial forever begin
    @(posedge clk);
    #1;
    if (pend) begin
      rd_data = mem[pend_addr];
      pend = 1'b0;
    end
  end

  initial begin
    #3_000_000;
    fails++;
    $display("FAIL global_timeout got=expired required=finish");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  function automatic int count_kind(int k);
    int n = 0;
    foreach (evq[i]) if (evq[i].kind == k) n++;
    return n;
  endfunction

  function automatic int first_diff();
    int n = (evq.size() < exp_q.size()) ? evq.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      if (evq[i].kind != exp_q[i].kind) return i;
      if (exp_q[i].kind == K_DATA && evq[i].data !== exp_q[i].data) return i;
    end
    if (evq.size() != exp_q.size()) return n;
    return -1;
  endfunction

  function automatic int addr_diff();
    int n = (fetchq.size() < exp_a.size()) ? fetchq.size() : exp_a.size();
    for (int i = 0; i < n; i++) if (fetchq[i] != exp_a[i]) return i;
    if (fetchq.size() != exp_a.size()) return n;
    return -1;
  endfunction

  // a frame is: image, then every column's words in address order, then the column advance
  task automatic add_expected_frame();
    exp_q.push_back('{K_IMG, '0, 0});
    for (int c = 0; c < COLS; c++) begin
      for (int b = 0; b < BPC; b++) begin
        exp_q.push_back('{K_DATA, mem[c*BPC + b], 0});
        exp_a.push_back(c*BPC + b);
      end
      exp_q.push_back('{K_COL, '0, 0});
    end
    exp_q.push_back('{K_DONE, '0, 0});
  endtask

  task automatic tick(int n);
    repeat (n) begin @(posedge clk); #2; end
  endtask

  task automatic clear_logs();
    evq.delete(); fetchq.delete(); exp_q.delete(); exp_a.delete();
    viol = 0; hold_viol = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1; enable = 1'b0; hold_hi = 0; busy_len = 4;
    tick(2);
    rst = 1'b0;
    clear_logs();
    for (int i = 0; i < COLS*BPC; i++) mem[i] = 24'($urandom);
  endtask

  task automatic wait_kind(int k, int n, string tag);
    for (int i = 0; i < 2000 && count_kind(k) < n; i++) tick(1);
    tests++;
    if (count_kind(k) < n) begin
      fails++;
      $display("FAIL %s_timeout got=%0d events required=%0d", tag, count_kind(k), n);
    end
  endtask

  task automatic test_reset();
    tests++;
    if ({rd_en, rd_addr, data_out, new_image, next_data, new_column, frame_done, busy} !== '0) begin
      fails++;
      $display("FAIL reset_outputs got rd_en=%b addr=%0d data=%h img=%b nd=%b col=%b done=%b busy=%b required all 0",
               rd_en, rd_addr, data_out, new_image, next_data, new_column, frame_done, busy);
    end
    do_reset();
    tick(10);
    tests++;
    if (busy !== 1'b0 || evq.size() != 0) begin
      fails++;
      $display("FAIL idle_without_enable got busy=%b events=%0d required busy=0 events=0", busy, evq.size());
    end
  endtask

  task automatic test_single_frame();
    int c_en, d, nd;
    logic [DW-1:0] fifth;
    do_reset();
    mem[4] = 24'h332211;
    add_expected_frame();
    c_en = cyc;
    enable = 1'b1;
    wait_kind(K_IMG, 1, "single_img");
    enable = 1'b0;
    wait_kind(K_DONE, 1, "single_done");
    tick(30);
    tests++;
    if (evq.size() == 0 || evq[0].cyc != c_en + 2) begin
      fails++;
      $display("FAIL img_latency got=%0d required=%0d", (evq.size() > 0) ? evq[0].cyc : -1, c_en + 2);
    end
    d = first_diff();
    tests++;
    if (d != -1) begin
      fails++;
      $display("FAIL single_seq index=%0d got_len=%0d required_len=%0d", d, evq.size(), exp_q.size());
    end
    d = addr_diff();
    tests++;
    if (d != -1) begin
      fails++;
      $display("FAIL single_addr index=%0d got=%0d required=%0d", d,
               (d < fetchq.size()) ? fetchq[d] : -1, (d < exp_a.size()) ? exp_a[d] : -1);
    end
    nd = 0; fifth = '0;
    foreach (evq[i]) if (evq[i].kind == K_DATA) begin
      nd++;
      if (nd == 5) fifth = evq[i].data;
    end
    tests++;
    if (fifth[7:0] !== 8'h11 || fifth[15:8] !== 8'h22 || fifth[23:16] !== 8'h33) begin
      fails++;
      $display("FAIL lane_bytes got=%h required=332211", fifth);
    end
    tests++;
    if (count_kind(K_IMG) != 1 || count_kind(K_DATA) != 6 || count_kind(K_COL) != 2 || count_kind(K_DONE) != 1) begin
      fails++;
      $display("FAIL single_counts got img=%0d data=%0d col=%0d done=%0d required 1/6/2/1",
               count_kind(K_IMG), count_kind(K_DATA), count_kind(K_COL), count_kind(K_DONE));
    end
    tests++;
    if (busy !== 1'b0 || viol != 0 || hold_viol != 0) begin
      fails++;
      $display("FAIL single_after got busy=%b viol=%0d hold_viol=%0d required 0/0/0", busy, viol, hold_viol);
    end
  endtask

  task automatic test_hold_high();
    int d;
    for (int it = 0; it < 3; it++) begin
      do_reset();
      hold_hi  = (it == 0) ? 3 : $urandom_range(0, 3);
      busy_len = $urandom_range(2, 6);
      add_expected_frame();
      enable = 1'b1;
      wait_kind(K_IMG, 1, "hold_img");
      enable = 1'b0;
      wait_kind(K_DONE, 1, "hold_done");
      tick(20);
      d = first_diff();
      tests++;
      if (d != -1 || addr_diff() != -1) begin
        fails++;
        $display("FAIL hold_seq iter=%0d index=%0d got_len=%0d required_len=%0d", it, d, evq.size(), exp_q.size());
      end
      tests++;
      if (viol != 0 || hold_viol != 0) begin
        fails++;
        $display("FAIL hold_protocol iter=%0d got viol=%0d hold_viol=%0d required 0", it, viol, hold_viol);
      end
    end
  endtask

  task automatic test_reset_mid_wait();
    int c_rel, d;
    do_reset();
    enable = 1'b1;
    wait_kind(K_DATA, 1, "mid_first_data");
    tick(2);
    rst = 1'b1;
    #1;
    tests++;
    if ({rd_en, rd_addr, data_out, new_image, next_data, new_column, frame_done, busy} !== '0) begin
      fails++;
      $display("FAIL async_reset got rd_en=%b addr=%0d data=%h img=%b nd=%b col=%b done=%b busy=%b required all 0",
               rd_en, rd_addr, data_out, new_image, next_data, new_column, frame_done, busy);
    end
    #1;
    tick(2);
    rst = 1'b0;
    clear_logs();
    add_expected_frame();
    c_rel = cyc;
    wait_kind(K_IMG, 1, "restart_img");
    enable = 1'b0;
    wait_kind(K_DONE, 1, "restart_done");
    tick(10);
    tests++;
    if (evq.size() == 0 || evq[0].kind != K_IMG || evq[0].cyc != c_rel + 2 ||
        fetchq.size() == 0 || fetchq[0] != 0) begin
      fails++;
      $display("FAIL restart_start got first_kind=%0d cyc=%0d first_addr=%0d required kind=0 cyc=%0d addr=0",
               (evq.size() > 0) ? evq[0].kind : -1, (evq.size() > 0) ? evq[0].cyc : -1,
               (fetchq.size() > 0) ? fetchq[0] : -1, c_rel + 2);
    end
    d = first_diff();
    tests++;
    if (d != -1 || addr_diff() != -1) begin
      fails++;
      $display("FAIL restart_seq index=%0d got_len=%0d required_len=%0d", d, evq.size(), exp_q.size());
    end
  endtask

  task automatic test_back_to_back();
    int d, di;
    do_reset();
    busy_len = $urandom_range(2, 6);
    add_expected_frame();
    add_expected_frame();
    enable = 1'b1;
    wait_kind(K_IMG, 2, "b2b_img2");
    enable = 1'b0;
    wait_kind(K_DONE, 2, "b2b_done2");
    tick(20);
    d = first_diff();
    tests++;
    if (d != -1) begin
      fails++;
      $display("FAIL b2b_seq index=%0d got_len=%0d required_len=%0d", d, evq.size(), exp_q.size());
    end
    d = addr_diff();
    tests++;
    if (d != -1) begin
      fails++;
      $display("FAIL b2b_addr index=%0d got=%0d required=%0d", d,
               (d < fetchq.size()) ? fetchq[d] : -1, (d < exp_a.size()) ? exp_a[d] : -1);
    end
    di = -1;
    foreach (evq[i]) if (di < 0 && evq[i].kind == K_DONE) di = i;
    tests++;
    if (di < 0 || di + 1 >= evq.size() || evq[di+1].kind != K_IMG || evq[di+1].cyc != evq[di].cyc + 1) begin
      fails++;
      $display("FAIL b2b_direct_restart got done_idx=%0d next_kind=%0d gap=%0d required kind=0 gap=1", di,
               (di >= 0 && di + 1 < evq.size()) ? evq[di+1].kind : -1,
               (di >= 0 && di + 1 < evq.size()) ? evq[di+1].cyc - evq[di].cyc : -1);
    end
    tests++;
    if (busy !== 1'b0 || viol != 0 || hold_viol != 0) begin
      fails++;
      $display("FAIL b2b_after got busy=%b viol=%0d hold_viol=%0d required 0/0/0", busy, viol, hold_viol);
    end
  endtask

  initial begin
    @(posedge clk);
    #2;
    test_reset();
    test_single_frame();
    test_hold_high();
    test_reset_mid_wait();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
